// File: rtl/tmds_pkg.sv
// TMDS symbol tables and mode encoding shared by the encoder bank.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package tmds_pkg;

   typedef enum logic [2:0] {
      MODE_CTRL      = 3'd0,
      MODE_VIDEO     = 3'd1,
      MODE_VIDEO_GB  = 3'd2,
      MODE_ISLAND    = 3'd3,
      MODE_ISLAND_GB = 3'd4
   } tmds_mode_t;

   // Indexed by {C1,C0}.
   localparam logic [9:0] CTRL_CODE [4] = '{
      10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
   };

   // Indexed by the 4-bit TERC4 nibble.
   localparam logic [9:0] TERC4_CODE [16] = '{
      10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
      10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
      10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
      10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
   };

   // Video leading guard band, indexed by channel.
   localparam logic [9:0] VIDEO_GB [3] = '{
      10'b1011001100, 10'b0100110011, 10'b1011001100
   };

   // Data island guard band on channels 1 and 2 (channel 0 carries TERC4 of sync).
   localparam logic [9:0] ISLAND_GB_CH12 = 10'b0100110011;

   // Population count of a byte, 0..8.
   function automatic logic [3:0] ones8(input logic [7:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
      return n;
   endfunction

endpackage

// File: rtl/tmds_encoder_bank_if.sv
// Bus between the HDMI mode sequencer and the TMDS encoder bank.
// Latency: n/a (wiring only).
// Backpressure: none; in_valid qualifies a word, out_valid marks each encoded word.
//   master: sequencer side (drives in_valid/mode/data, observes tmds/disparity)
//   slave : encoder side
interface tmds_encoder_bank_if #(
   parameter int NUM_CHANNELS     = 3,
   parameter int PIXELS_PER_CLOCK = 1
);
   logic                                                  in_valid;
   logic [PIXELS_PER_CLOCK-1:0][2:0]                      mode;
   logic [PIXELS_PER_CLOCK-1:0][NUM_CHANNELS-1:0][7:0]    video_data;
   logic [PIXELS_PER_CLOCK-1:0][NUM_CHANNELS-1:0][3:0]    data_island_data;
   logic [PIXELS_PER_CLOCK-1:0][NUM_CHANNELS-1:0][1:0]    control_data;
   logic                                                  out_valid;
   logic [PIXELS_PER_CLOCK-1:0][NUM_CHANNELS-1:0][9:0]    tmds;
   logic [NUM_CHANNELS-1:0][4:0]                          disparity;

   modport master (
      output in_valid, mode, video_data, data_island_data, control_data,
      input  out_valid, tmds, disparity
   );

   modport slave (
      input  in_valid, mode, video_data, data_island_data, control_data,
      output out_valid, tmds, disparity
   );
endinterface

// File: rtl/tmds_qm_stage.sv
// Transition-minimising first step of TMDS video coding: byte D -> q_m[8:0] and N1(q_m[7:0]).
// Latency: combinational.
// Backpressure: none.
//   d   : input pixel byte
//   q_m : transition-minimised word, q_m[8]=1 means the XOR chain was used
//   n1  : number of ones in q_m[7:0]
module tmds_qm_stage
   import tmds_pkg::*;
(
   input  logic [7:0] d,
   output logic [8:0] q_m,
   output logic [3:0] n1
);

   logic [3:0] n1_d;
   logic       use_xnor;
   logic [7:0] chain;

   always_comb begin
      n1_d     = ones8(d);
      use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !d[0]);
      chain    = 8'h00;
      chain[0] = d[0];
      for (int i = 1; i < 8; i++) begin
         chain[i] = use_xnor ? ~(chain[i-1] ^ d[i]) : (chain[i-1] ^ d[i]);
      end
   end

   assign q_m = {~use_xnor, chain};
   assign n1  = ones8(chain);

endmodule

// File: rtl/tmds_encoder_bank.sv
// Multi-channel, multi-lane TMDS encoder (video 8b/10b, control, TERC4, guard bands).
// Latency: a word captured at one clk_pixel edge appears on tmds after the following edge.
// Backpressure: none; in_valid=0 inserts a bubble, outputs and disparity hold through it.
//   clk_pixel : word clock
//   reset     : synchronous, active-high
//   bus       : slave side of tmds_encoder_bank_if (inputs, tmds words, per-channel disparity)
module tmds_encoder_bank
   import tmds_pkg::*;
#(
   parameter int NUM_CHANNELS     = 3,
   parameter int PIXELS_PER_CLOCK = 1
) (
   input  logic                 clk_pixel,
   input  logic                 reset,
   tmds_encoder_bank_if.slave   bus
);

   localparam int NCH = NUM_CHANNELS;
   localparam int PPC = PIXELS_PER_CLOCK;

   // ---------------- stage 1: q_m and N1 per lane/channel ----------------
   logic [PPC-1:0][NCH-1:0][8:0] qm_c;
   logic [PPC-1:0][NCH-1:0][3:0] n1_c;

   for (genvar l = 0; l < PPC; l++) begin : g_qm_lane
      for (genvar c = 0; c < NCH; c++) begin : g_qm_ch
         tmds_qm_stage u_qm (
            .d   (bus.video_data[l][c]),
            .q_m (qm_c[l][c]),
            .n1  (n1_c[l][c])
         );
      end
   end

   logic                          s1_vld;
   logic [PPC-1:0][2:0]           s1_mode;
   logic [PPC-1:0][NCH-1:0][8:0]  s1_qm;
   logic [PPC-1:0][NCH-1:0][3:0]  s1_n1;
   logic [PPC-1:0][NCH-1:0][1:0]  s1_ctrl;
   logic [PPC-1:0][NCH-1:0][3:0]  s1_terc;

   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         s1_vld <= 1'b0;
      end else begin
         s1_vld <= bus.in_valid;
         if (bus.in_valid) begin
            s1_mode <= bus.mode;
            s1_qm   <= qm_c;
            s1_n1   <= n1_c;
            s1_ctrl <= bus.control_data;
            s1_terc <= bus.data_island_data;
         end
      end
   end

   // ---------------- stage 2: disparity chain across lanes ----------------
   logic                          out_valid_q;
   logic [PPC-1:0][NCH-1:0][9:0]  tmds_q;
   logic [NCH-1:0][4:0]           disp_q;
   logic [PPC-1:0][NCH-1:0][9:0]  tmds_nxt;
   logic [NCH-1:0][4:0]           disp_nxt;

   for (genvar c = 0; c < NCH; c++) begin : g_chain
      logic [PPC-1:0][9:0] sym;
      logic signed [4:0]   cnt_end;

      always_comb begin
         logic signed [4:0] cnt;
         logic signed [4:0] diff;
         logic              q8;
         logic [7:0]        qm;
         logic [3:0]        n1;
         cnt  = $signed(disp_q[c]);
         sym  = '0;
         diff = 5'sd0;
         q8   = 1'b0;
         qm   = 8'h00;
         n1   = 4'd0;
         for (int l = 0; l < PPC; l++) begin
            q8   = s1_qm[l][c][8];
            qm   = s1_qm[l][c][7:0];
            n1   = s1_n1[l][c];
            // N1 - N0 of q_m[7:0]; 5-bit wrap is intentional (range -8..+8).
            diff = $signed({n1, 1'b0}) - 5'sd8;
            case (s1_mode[l])
               MODE_VIDEO: begin
                  if ((cnt == 5'sd0) || (n1 == 4'd4)) begin
                     sym[l] = {~q8, q8, q8 ? qm : ~qm};
                     cnt    = cnt + (q8 ? diff : -diff);
                  end else if (((cnt > 5'sd0) && (n1 > 4'd4)) ||
                               ((cnt < 5'sd0) && (n1 < 4'd4))) begin
                     sym[l] = {1'b1, q8, ~qm};
                     cnt    = cnt + (q8 ? 5'sd2 : 5'sd0) - diff;
                  end else begin
                     sym[l] = {1'b0, q8, qm};
                     cnt    = cnt + diff - (q8 ? 5'sd0 : 5'sd2);
                  end
               end
               MODE_VIDEO_GB: begin
                  sym[l] = VIDEO_GB[c];
                  cnt    = 5'sd0;
               end
               MODE_ISLAND: begin
                  sym[l] = TERC4_CODE[s1_terc[l][c]];
                  cnt    = 5'sd0;
               end
               MODE_ISLAND_GB: begin
                  // Channel 0 keeps hsync/vsync visible through the guard band.
                  sym[l] = (c == 0) ? TERC4_CODE[{2'b11, s1_ctrl[l][c]}] : ISLAND_GB_CH12;
                  cnt    = 5'sd0;
               end
               default: begin
                  // Control period, and the fallback for undefined modes.
                  sym[l] = CTRL_CODE[s1_ctrl[l][c]];
                  cnt    = 5'sd0;
               end
            endcase
         end
         cnt_end = cnt;
      end

      for (genvar l = 0; l < PPC; l++) begin : g_sym
         assign tmds_nxt[l][c] = sym[l];
      end
      assign disp_nxt[c] = cnt_end;
   end

   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         disp_q      <= '0;
         for (int l = 0; l < PPC; l++) begin
            for (int c = 0; c < NCH; c++) begin
               tmds_q[l][c] <= CTRL_CODE[0];
            end
         end
      end else begin
         out_valid_q <= s1_vld;
         if (s1_vld) begin
            tmds_q <= tmds_nxt;
            disp_q <= disp_nxt;
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.tmds      = tmds_q;
   assign bus.disparity = disp_q;

endmodule

// File: tb/tb_tmds_encoder_bank.sv
`timescale 1ns/1ps
module tb_tmds_encoder_bank;

   localparam int NCH = 3;
   localparam int PPC = 2;

   logic clk_pixel;
   logic reset;

   initial begin
      clk_pixel = 1'b0;
      forever #5 clk_pixel = ~clk_pixel;
   end

   tmds_encoder_bank_if #(.NUM_CHANNELS(NCH), .PIXELS_PER_CLOCK(PPC)) bus ();

   tmds_encoder_bank #(.NUM_CHANNELS(NCH), .PIXELS_PER_CLOCK(PPC)) dut (
      .clk_pixel (clk_pixel),
      .reset     (reset),
      .bus       (bus)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- reference tables and coding rules ----------------
   function automatic bit [9:0] ctrl_sym(input bit [1:0] c);
      case (c)
         2'b00:   return 10'b1101010100;
         2'b01:   return 10'b0010101011;
         2'b10:   return 10'b0101010100;
         default: return 10'b1010101011;
      endcase
   endfunction

   function automatic bit [9:0] terc4(input bit [3:0] n);
      case (n)
         4'h0: return 10'b1010011100;  4'h1: return 10'b1001100011;
         4'h2: return 10'b1011100100;  4'h3: return 10'b1011100010;
         4'h4: return 10'b0101110001;  4'h5: return 10'b0100011110;
         4'h6: return 10'b0110001110;  4'h7: return 10'b0100111100;
         4'h8: return 10'b1011001100;  4'h9: return 10'b0100111001;
         4'hA: return 10'b0110011100;  4'hB: return 10'b1011000110;
         4'hC: return 10'b1010001110;  4'hD: return 10'b1001110001;
         4'hE: return 10'b0101100011;  default: return 10'b1011000011;
      endcase
   endfunction

   // Symbol choice for a video byte given the incoming running disparity.
   // The disparity update is taken from the emitted symbol itself (ones - zeros).
   function automatic bit [9:0] enc_video(input bit [7:0] d, input int cnt);
      bit [8:0] qm;
      int       n1d;
      int       n1;
      bit       xn;
      n1d   = $countones(d);
      xn    = (n1d > 4) || (n1d == 4 && !d[0]);
      qm    = '0;
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = !xn;
      n1    = $countones(qm[7:0]);
      if (cnt == 0 || n1 == 4) return {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      if ((cnt > 0 && n1 > 4) || (cnt < 0 && n1 < 4)) return {1'b1, qm[8], ~qm[7:0]};
      return {1'b0, qm[8], qm[7:0]};
   endfunction

   // ---------------- behavioural model ----------------
   bit        model_live = 1'b0;
   bit        m_vld;
   bit [9:0]  m_tmds [PPC][NCH];
   int        m_disp [NCH];
   // the word captured on the previous edge, waiting to be encoded
   bit        h_vld;
   bit [2:0]  h_mode [PPC];
   bit [7:0]  h_vd   [PPC][NCH];
   bit [3:0]  h_id   [PPC][NCH];
   bit [1:0]  h_cd   [PPC][NCH];

   always @(posedge clk_pixel) begin
      if (reset) begin
         model_live = 1'b1;
         m_vld      = 1'b0;
         h_vld      = 1'b0;
         for (int c = 0; c < NCH; c++) begin
            m_disp[c] = 0;
            for (int l = 0; l < PPC; l++) m_tmds[l][c] = 10'b1101010100;
         end
      end else if (model_live) begin
         m_vld = h_vld;
         if (h_vld) begin
            for (int c = 0; c < NCH; c++) begin
               int cnt;
               cnt = m_disp[c];
               for (int l = 0; l < PPC; l++) begin
                  bit [9:0] s;
                  case (h_mode[l])
                     3'd1: begin
                        s   = enc_video(h_vd[l][c], cnt);
                        cnt = cnt + 2 * $countones(s) - 10;
                     end
                     3'd2: begin s = (c == 1) ? 10'b0100110011 : 10'b1011001100; cnt = 0; end
                     3'd3: begin s = terc4(h_id[l][c]); cnt = 0; end
                     3'd4: begin
                        s   = (c == 0) ? terc4({2'b11, h_cd[l][0]}) : 10'b0100110011;
                        cnt = 0;
                     end
                     default: begin s = ctrl_sym(h_cd[l][c]); cnt = 0; end
                  endcase
                  m_tmds[l][c] = s;
               end
               m_disp[c] = cnt;
            end
         end
         h_vld = bus.in_valid;
         if (bus.in_valid) begin
            for (int l = 0; l < PPC; l++) begin
               h_mode[l] = bus.mode[l];
               for (int c = 0; c < NCH; c++) begin
                  h_vd[l][c] = bus.video_data[l][c];
                  h_id[l][c] = bus.data_island_data[l][c];
                  h_cd[l][c] = bus.control_data[l][c];
               end
            end
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] sext5(input logic [4:0] v);
      return {{27{v[4]}}, v};
   endfunction

   always @(negedge clk_pixel) begin
      if (model_live) begin
         chk("out_valid", {31'b0, bus.out_valid}, {31'b0, m_vld});
         for (int c = 0; c < NCH; c++) begin
            for (int l = 0; l < PPC; l++)
               chk($sformatf("model tmds[%0d][%0d]", l, c), {22'b0, bus.tmds[l][c]}, {22'b0, m_tmds[l][c]});
            chk($sformatf("model disparity[%0d]", c), sext5(bus.disparity[c]), m_disp[c]);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk_pixel);
      #1;
   endtask

   task automatic set_idle();
      bus.in_valid         = 1'b0;
      bus.mode             = '0;
      bus.video_data       = '0;
      bus.data_island_data = '0;
      bus.control_data     = '0;
   endtask

   // Present the current inputs for one word, then wait until it is on tmds.
   task automatic send_one();
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      @(posedge clk_pixel);
      @(negedge clk_pixel);
   endtask

   task automatic rand_word(input int video_pct);
      for (int l = 0; l < PPC; l++) begin
         bus.mode[l] = ($urandom_range(99) < video_pct) ? 3'd1 : 3'($urandom_range(7));
         for (int c = 0; c < NCH; c++) begin
            bus.video_data[l][c]       = 8'($urandom);
            bus.data_island_data[l][c] = 4'($urandom);
            bus.control_data[l][c]     = 2'($urandom);
         end
      end
   endtask

   task automatic chk_all_sym(input string name, input logic [9:0] exp);
      for (int l = 0; l < PPC; l++)
         for (int c = 0; c < NCH; c++)
            chk($sformatf("%s[%0d][%0d]", name, l, c), {22'b0, bus.tmds[l][c]}, {22'b0, exp});
   endtask

   task automatic chk_all_disp(input string name, input int exp);
      for (int c = 0; c < NCH; c++)
         chk($sformatf("%s[%0d]", name, c), sext5(bus.disparity[c]), exp);
   endtask

   initial begin
      set_idle();
      reset = 1'b1;
      repeat (3) @(posedge clk_pixel);
      #1 reset = 1'b0;
      @(posedge clk_pixel);
      @(negedge clk_pixel);
      chk("reset out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk_all_sym("reset tmds", 10'b1101010100);
      chk_all_disp("reset disparity", 0);

      // control symbols on channel 0
      bus.mode                = '0;
      bus.control_data[0][0]  = 2'b01;
      bus.control_data[1][0]  = 2'b11;
      send_one();
      chk("ctrl lane0 ch0", {22'b0, bus.tmds[0][0]}, {22'b0, 10'b0010101011});
      chk("ctrl lane1 ch0", {22'b0, bus.tmds[1][0]}, {22'b0, 10'b1010101011});
      chk("ctrl valid", {31'b0, bus.out_valid}, 32'd1);

      // video 0x00 from zero disparity
      set_idle();
      bus.mode[0] = 3'd1;
      bus.mode[1] = 3'd1;
      send_one();
      for (int c = 0; c < NCH; c++) begin
         chk($sformatf("video00 lane0 ch%0d", c), {22'b0, bus.tmds[0][c]}, {22'b0, 10'b0100000000});
         chk($sformatf("video00 lane1 ch%0d", c), {22'b0, bus.tmds[1][c]}, {22'b0, 10'b1111111111});
      end
      chk_all_disp("video00 disparity", 2);

      // video guard band resets the chain
      bus.mode[0] = 3'd2;
      bus.mode[1] = 3'd2;
      send_one();
      chk("vgb ch0", {22'b0, bus.tmds[0][0]}, {22'b0, 10'b1011001100});
      chk("vgb ch1", {22'b0, bus.tmds[1][1]}, {22'b0, 10'b0100110011});
      chk("vgb ch2", {22'b0, bus.tmds[0][2]}, {22'b0, 10'b1011001100});
      chk_all_disp("vgb disparity", 0);

      bus.mode[0] = 3'd1;
      bus.mode[1] = 3'd1;
      send_one();
      chk("video after gb lane0 ch0", {22'b0, bus.tmds[0][0]}, {22'b0, 10'b0100000000});

      // island guard band then TERC4 nibble 0
      set_idle();
      bus.mode[0] = 3'd4;
      bus.mode[1] = 3'd4;
      bus.control_data[0][0] = 2'b10;
      bus.control_data[1][0] = 2'b10;
      send_one();
      chk("igb ch0", {22'b0, bus.tmds[0][0]}, {22'b0, 10'b0101100011});
      chk("igb ch1", {22'b0, bus.tmds[0][1]}, {22'b0, 10'b0100110011});
      chk("igb ch2", {22'b0, bus.tmds[1][2]}, {22'b0, 10'b0100110011});
      set_idle();
      bus.mode[0] = 3'd3;
      bus.mode[1] = 3'd3;
      send_one();
      chk_all_sym("terc4 nibble0", 10'b1010011100);

      // back-to-back video with a 3-cycle in_valid gap in the middle
      for (int i = 0; i < 10; i++) begin
         rand_word(100);
         bus.in_valid = 1'b1;
         tick();
         if (i == 4) begin
            bus.in_valid = 1'b0;
            repeat (3) tick();
         end
      end
      bus.in_valid = 1'b0;
      repeat (3) tick();

      // reset pulse with the pipeline full
      for (int i = 0; i < 4; i++) begin
         rand_word(70);
         bus.in_valid = 1'b1;
         tick();
      end
      reset = 1'b1;
      @(posedge clk_pixel);
      @(negedge clk_pixel);
      chk("pulse out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk_all_sym("pulse tmds", 10'b1101010100);
      chk_all_disp("pulse disparity", 0);
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      repeat (2) begin
         @(negedge clk_pixel);
         chk("no stale word", {31'b0, bus.out_valid}, 32'd0);
      end

      // long randomized run
      for (int i = 0; i < 1500; i++) begin
         rand_word(60);
         bus.in_valid = ($urandom_range(99) < 80);
         tick();
      end
      set_idle();
      repeat (4) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
